cpu_sequencer: RTL and testbench

Synchronous fetch/decode/execute controller for the 16-word, 8-bit-instruction CPU datapath. It owns the program counter, instruction register and condition flags, and sequences the external instruction/data memory (16x8), the 4-entry register file (REG_A..REG_D) and the ALU one instruction at a time until HALT. It is the clocked counterpart of the existing handshake-driven control path and executes the same ISA and memory image.

---
 rtl/cpu_sequencer.sv | 157 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller for the 16x8 accumulator-style CPU.
// Owns pc, ir and flags; drives memory, register file and ALU controls.
module cpu_sequencer (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_run,
  input  logic [7:0] i_mem_rdata,
  input  logic       i_alu_neg,
  input  logic       i_alu_zero,
  input  logic       i_alu_of,
  output logic [3:0] o_mem_addr,
  output logic       o_mem_rd,
  output logic       o_mem_wr,
  output logic [1:0] o_rf_raddr_a,
  output logic [1:0] o_rf_raddr_b,
  output logic       o_rf_we,
  output logic [1:0] o_rf_waddr,
  output logic       o_rf_wsel,
  output logic [1:0] o_alu_op,
  output logic [3:0] o_pc,
  output logic [7:0] o_ir,
  output logic       o_flag_neg,
  output logic       o_flag_zero,
  output logic       o_flag_of,
  output logic       o_halted,
  output logic [7:0] o_retired
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALTED
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_pc;
  logic [7:0] r_ir;
  logic       r_neg;
  logic       r_zero;
  logic       r_of;
  logic [7:0] r_retired;

  logic [3:0] w_pc_nxt;
  logic       w_ir_ld;
  logic       w_flag_en;
  logic       w_retire;
  logic [3:0] w_opc;
  logic [3:0] w_opd;

  assign w_opc = r_ir[7:4];
  assign w_opd = r_ir[3:0];

  always_comb begin
    w_next       = r_state;
    w_pc_nxt     = r_pc;
    w_ir_ld      = 1'b0;
    w_flag_en    = 1'b0;
    w_retire     = 1'b0;
    o_mem_addr   = 4'd0;
    o_mem_rd     = 1'b0;
    o_mem_wr     = 1'b0;
    o_rf_raddr_a = 2'd0;
    o_rf_raddr_b = 2'd0;
    o_rf_we      = 1'b0;
    o_rf_waddr   = 2'd0;
    o_rf_wsel    = 1'b0;
    o_alu_op     = 2'd0;
    unique case (r_state)
      S_FETCH: begin
        if (i_run) begin
          o_mem_addr = r_pc;
          o_mem_rd   = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        w_ir_ld  = 1'b1;
        w_pc_nxt = r_pc + 4'd1;
        w_next   = S_EXEC;
      end
      S_EXEC: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
        unique case (w_opc)
          4'h0: ;
          4'h1: w_next = S_HALTED;
          4'h2: w_pc_nxt = w_opd;
          4'h3: if (r_neg) w_pc_nxt = w_opd;
          4'h4, 4'h5, 4'h6, 4'h7: begin
            o_mem_addr = w_opd;
            o_mem_rd   = 1'b1;
            w_next     = S_WB;
            w_retire   = 1'b0;
          end
          4'h8, 4'h9, 4'hA, 4'hB: begin
            // reset aborts the store so no partial instruction lands
            o_rf_raddr_a = w_opc[1:0];
            o_mem_addr   = w_opd;
            o_mem_wr     = ~i_rst;
          end
          default: begin
            o_rf_raddr_a = r_ir[3:2];
            o_rf_raddr_b = r_ir[1:0];
            o_rf_we      = ~i_rst;
            o_rf_waddr   = r_ir[3:2];
            o_rf_wsel    = 1'b1;
            o_alu_op     = w_opc[1:0];
            w_flag_en    = 1'b1;
          end
        endcase
      end
      S_WB: begin
        o_rf_we    = ~i_rst;
        o_rf_waddr = w_opc[1:0];
        o_rf_wsel  = 1'b0;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_HALTED: ;
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_FETCH;
      r_pc      <= 4'd0;
      r_ir      <= 8'd0;
      r_neg     <= 1'b0;
      r_zero    <= 1'b0;
      r_of      <= 1'b0;
      r_retired <= 8'd0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_nxt;
      if (w_ir_ld) r_ir <= i_mem_rdata;
      if (w_flag_en) begin
        r_neg  <= i_alu_neg;
        r_zero <= i_alu_zero;
        r_of   <= i_alu_of;
      end
      if (w_retire) r_retired <= r_retired + 8'd1;
    end
  end

  assign o_pc        = r_pc;
  assign o_ir        = r_ir;
  assign o_flag_neg  = r_neg;
  assign o_flag_zero = r_zero;
  assign o_flag_of   = r_of;
  assign o_halted    = (r_state == S_HALTED);
  assign o_retired   = r_retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: memory, register file and ALU models around
// the DUT; write strobes are checked against a queue of expected events.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [7:0] mem_rdata;
  logic       alu_neg;
  logic       alu_zero;
  logic       alu_of;
  logic [3:0] mem_addr;
  logic       mem_rd;
  logic       mem_wr;
  logic [1:0] raddr_a;
  logic [1:0] raddr_b;
  logic       rf_we;
  logic [1:0] waddr;
  logic       wsel;
  logic [1:0] alu_op;
  logic [3:0] pc;
  logic [7:0] ir;
  logic       f_neg;
  logic       f_zero;
  logic       f_of;
  logic       halted;
  logic [7:0] retired;

  cpu_sequencer dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_run(run),
    .i_mem_rdata(mem_rdata),
    .i_alu_neg(alu_neg),
    .i_alu_zero(alu_zero),
    .i_alu_of(alu_of),
    .o_mem_addr(mem_addr),
    .o_mem_rd(mem_rd),
    .o_mem_wr(mem_wr),
    .o_rf_raddr_a(raddr_a),
    .o_rf_raddr_b(raddr_b),
    .o_rf_we(rf_we),
    .o_rf_waddr(waddr),
    .o_rf_wsel(wsel),
    .o_alu_op(alu_op),
    .o_pc(pc),
    .o_ir(ir),
    .o_flag_neg(f_neg),
    .o_flag_zero(f_zero),
    .o_flag_of(f_of),
    .o_halted(halted),
    .o_retired(retired)
  );

  always #5 clk = ~clk;

  logic [7:0] img [16];
  logic [7:0] mem [16];
  logic [7:0] rf  [4];
  logic       do_load = 1'b0;
  logic [7:0] a_v, b_v, res;

  always_comb begin
    a_v = rf[raddr_a];
    b_v = rf[raddr_b];
    res = 8'd0;
    alu_of = 1'b0;
    case (alu_op)
      2'd0: begin
        res = a_v + b_v;
        alu_of = (a_v[7] == b_v[7]) && (res[7] != a_v[7]);
      end
      2'd1: begin
        res = a_v - b_v;
        alu_of = (a_v[7] != b_v[7]) && (res[7] != a_v[7]);
      end
      2'd2: res = a_v & b_v;
      default: res = a_v | b_v;
    endcase
    alu_neg = res[7];
    alu_zero = (res == 8'd0);
  end

  always @(posedge clk) begin
    if (do_load) begin
      for (int i = 0; i < 16; i++) mem[i] <= img[i];
      for (int i = 0; i < 4; i++) rf[i] <= 8'd0;
    end else begin
      if (mem_wr) mem[mem_addr] <= rf[raddr_a];
      if (rf_we) rf[waddr] <= wsel ? res : mem_rdata;
    end
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] addr;
    logic [1:0] ra;
    logic       sel;
    logic [1:0] op;
    logic [7:0] data;
  } ev_t;

  localparam logic [1:0] K_RF  = 2'd1;
  localparam logic [1:0] K_MEM = 2'd2;

  ev_t q[$];
  int  checks = 0;
  int  fails  = 0;
  int  cyc;

  function automatic ev_t ev(input logic [1:0] k, input logic [3:0] a,
                             input logic [1:0] r, input logic s,
                             input logic [1:0] o, input logic [7:0] d);
    ev_t e;
    e = '{kind: k, addr: a, ra: r, sel: s, op: o, data: d};
    return e;
  endfunction

  always @(negedge clk) begin
    if (rf_we || mem_wr) begin
      ev_t act, exp;
      act.kind = rf_we ? K_RF : K_MEM;
      act.addr = rf_we ? {2'b00, waddr} : mem_addr;
      act.ra   = raddr_a;
      act.sel  = wsel;
      act.op   = alu_op;
      act.data = rf_we ? (wsel ? res : mem_rdata) : rf[raddr_a];
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got %h want none", act);
      end else begin
        exp = q.pop_front();
        if (act !== exp) begin
          fails++;
          $display("FAIL sb_event: got %h want %h", act, exp);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clr_img();
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    do_load = 1'b1;
    @(posedge clk); #1;
    do_load = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic start();
    rst = 1'b0;
    run = 1'b1;
    cyc = 0;
  endtask

  task automatic wait_ir(input logic [7:0] v);
    while (ir !== v && cyc < 200) step();
    chk("wait_ir_timeout", {24'd0, ir}, {24'd0, v});
  endtask

  task automatic wait_halt();
    while (halted !== 1'b1 && cyc < 200) step();
    chk("halt_timeout", {31'd0, halted}, 32'd1);
  endtask

  initial begin
    clr_img();
    // reset with run low: everything idle
    rst = 1'b1;
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("rst_idle", {16'd0, pc, halted, mem_rd, mem_wr, rf_we, retired},
          32'd0);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("run_low_hold", {27'd0, pc, mem_rd}, 32'd0);

    // READ_A 14, READ_B 15, ADD A,B, HALT
    clr_img();
    img[0] = 8'h4E; img[1] = 8'h5F; img[2] = 8'hC1; img[3] = 8'h10;
    img[14] = 8'd3; img[15] = 8'd5;
    do_reset();
    q.push_back(ev(K_RF, 4'd0, 2'd0, 1'b0, 2'd0, 8'd3));
    q.push_back(ev(K_RF, 4'd1, 2'd0, 1'b0, 2'd0, 8'd5));
    q.push_back(ev(K_RF, 4'd0, 2'd0, 1'b1, 2'd0, 8'd8));
    start();
    wait_halt();
    chk("p1_halt_cycle", cyc, 14);
    chk("p1_retired", {24'd0, retired}, 32'd4);
    chk("p1_flags", {29'd0, f_neg, f_zero, f_of}, 32'd0);
    chk("p1_drain", q.size(), 0);

    // SUB A,B negative then JUMP_NEG 9 taken
    clr_img();
    img[0] = 8'h4E; img[1] = 8'h5F; img[2] = 8'hD1; img[3] = 8'h39;
    img[4] = 8'h10; img[9] = 8'h10;
    img[14] = 8'd3; img[15] = 8'd5;
    do_reset();
    q.push_back(ev(K_RF, 4'd0, 2'd0, 1'b0, 2'd0, 8'd3));
    q.push_back(ev(K_RF, 4'd1, 2'd0, 1'b0, 2'd0, 8'd5));
    q.push_back(ev(K_RF, 4'd0, 2'd0, 1'b1, 2'd1, 8'hFE));
    start();
    wait_ir(8'h39);
    step();
    chk("jn_taken_pc", {28'd0, pc}, 32'd9);
    wait_halt();
    chk("jn_taken_halt_pc", {28'd0, pc}, 32'd10);
    chk("jn_taken_flags", {29'd0, f_neg, f_zero, f_of}, 32'b100);
    chk("jn_taken_retired", {24'd0, retired}, 32'd5);
    chk("jn_taken_drain", q.size(), 0);

    // SUB B,A positive: JUMP_NEG falls through
    img[2] = 8'hD4;
    do_reset();
    q.push_back(ev(K_RF, 4'd0, 2'd0, 1'b0, 2'd0, 8'd3));
    q.push_back(ev(K_RF, 4'd1, 2'd0, 1'b0, 2'd0, 8'd5));
    q.push_back(ev(K_RF, 4'd1, 2'd1, 1'b1, 2'd1, 8'd2));
    start();
    wait_ir(8'h39);
    step();
    chk("jn_fall_pc", {28'd0, pc}, 32'd4);
    wait_halt();
    chk("jn_fall_halt_pc", {28'd0, pc}, 32'd5);
    chk("jn_fall_flags", {29'd0, f_neg, f_zero, f_of}, 32'b000);
    chk("jn_fall_drain", q.size(), 0);

    // stores, self-patched HALT at 0, NOP at 15 wraps pc to 0
    clr_img();
    img[0] = 8'h6E; img[1] = 8'hDF; img[2] = 8'hA7; img[3] = 8'hA0;
    img[4] = 8'h2F; img[15] = 8'h00; img[14] = 8'h10;
    do_reset();
    q.push_back(ev(K_RF, 4'd2, 2'd0, 1'b0, 2'd0, 8'h10));
    q.push_back(ev(K_RF, 4'd3, 2'd3, 1'b1, 2'd1, 8'h00));
    q.push_back(ev(K_MEM, 4'd7, 2'd2, 1'b0, 2'd0, 8'h10));
    q.push_back(ev(K_MEM, 4'd0, 2'd2, 1'b0, 2'd0, 8'h10));
    start();
    wait_halt();
    chk("wrap_halt_ir", {24'd0, ir}, 32'h10);
    chk("wrap_halt_pc", {28'd0, pc}, 32'd1);
    chk("load_flags_kept", {29'd0, f_neg, f_zero, f_of}, 32'b010);
    chk("wrap_retired", {24'd0, retired}, 32'd7);
    chk("load_mem7", {24'd0, mem[7]}, 32'h10);
    chk("wrap_drain", q.size(), 0);

    // reset during the WB of a READ
    clr_img();
    img[0] = 8'h4E; img[14] = 8'h77;
    do_reset();
    start();
    step(); step(); step();
    chk("wb_pre_state", {20'd0, pc, ir}, {20'd0, 4'd1, 8'h4E});
    rst = 1'b1;
    #1;
    chk("wb_rst_no_we", {31'd0, rf_we}, 32'd0);
    step();
    chk("wb_rst_regs", {16'd0, pc, ir, halted, retired[2:0]}, 32'd0);
    chk("wb_rst_fetch", {27'd0, mem_rd, mem_addr}, {27'd0, 1'b1, 4'd0});
    chk("wb_rst_rf_a", {24'd0, rf[0]}, 32'd0);
    chk("wb_drain", q.size(), 0);
    run = 1'b0;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
